// File: rtl/fas_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fas_issue_ctrl
//
// Purpose:
//   This block shares one fixed-latency float add/sub pipeline between two
//   requesters. The pipeline has a valid strobe only and cannot stall.
//   - Round-robin arbitration picks which requester issues each cycle.
//   - The selected operands are registered onto the pipeline inputs.
//   - Owner and tag of each in-flight op travel down a shift register whose
//     length matches the pipeline latency.
//   - Each returning result is steered to the requester that issued it.
//   - A per-requester limit on outstanding ops replaces result backpressure,
//     because the response ports have no ready signal.
//
// Parameters:
//   LAT      Cycles from fas_enable to the matching fas_valid. Legal: 1..16.
//   MAX_OUT  Maximum ops outstanding per requester. Legal: 1..15.
//   TAG_W    Width of the requester tag carried with each op.
//
// Ports:
//   clk, rst                      Clock (rising edge). Synchronous active-high reset.
//   reqN_valid/ready              Operand handshake for requester N (N = 0, 1).
//   reqN_a/b/sub/tag              Operands, op select (1 = A-B) and tag.
//   fas_enable/a/b/sub            Issue strobe and operands to the pipeline.
//   fas_valid/result              Result strobe and value from the pipeline.
//   rspN_valid/data/tag           One-cycle result pulse to requester N.
//   busy                          High while any op is issued, in flight, or
//                                 its response is pending.
//   seq_err                       Sticky. fas_valid and the tracked slot disagreed.
//
// Optional build macro FAS_CTRL_PERF_EN:
//   When defined, this adds saturating 16-bit counters:
//     perf_issue0, perf_issue1  Grants per requester.
//     perf_conflict             Cycles in which both requesters are valid.
// -----------------------------------------------------------------------------
module fas_issue_ctrl #(
  parameter int LAT     = 4,
  parameter int MAX_OUT = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req0_sub,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic             req1_sub,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             fas_enable,
  output logic [31:0]      fas_a,
  output logic [31:0]      fas_b,
  output logic             fas_sub,
  input  logic             fas_valid,
  input  logic [31:0]      fas_result,
  output logic             rsp0_valid,
  output logic [31:0]      rsp0_data,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  output logic [31:0]      rsp1_data,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             busy,
  output logic             seq_err
`ifdef FAS_CTRL_PERF_EN
  ,
  output logic [15:0]      perf_issue0,
  output logic [15:0]      perf_issue1,
  output logic [15:0]      perf_conflict
`endif
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Outstanding-op counters and round-robin state.
  // last_gnt_reg = 1 means requester 1 was granted last.
  logic [CNT_W-1:0] out0_reg, out0_next;
  logic [CNT_W-1:0] out1_reg, out1_next;
  logic             last_gnt_reg;

  // Owner and tag of the op currently on the fas_* outputs.
  // Slot 0 captures them in the same cycle that fas_enable is high.
  logic             issue_owner_reg;
  logic [TAG_W-1:0] issue_tag_reg;

  // Tracking shift register. Slot LAT-1 lines up with fas_valid.
  logic [LAT-1:0]       slot_vld_reg, slot_vld_next;
  logic [LAT-1:0]       slot_owner_reg, slot_owner_next;
  logic [LAT*TAG_W-1:0] slot_tag_reg, slot_tag_next;

  logic             last_vld;
  logic             last_owner;
  logic [TAG_W-1:0] last_tag;
  logic             ret0, ret1;
  logic             elig0, elig1;
  logic             cand0, cand1;
  logic             gnt0, gnt1;
  logic             dec0, dec1;

  assign last_vld   = slot_vld_reg[LAT-1];
  assign last_owner = slot_owner_reg[LAT-1];
  assign last_tag   = slot_tag_reg[(LAT-1)*TAG_W +: TAG_W];

  // A "return" is the tracked op leaving the last slot. The counter is freed
  // even when fas_valid is missing. Otherwise a lost result would leak a
  // credit forever.
  assign ret0 = last_vld & ~last_owner;
  assign ret1 = last_vld &  last_owner;

  // At the limit, a same-cycle return frees a credit for the new op.
  assign elig0 = (out0_reg < MAX_CNT) | ((out0_reg == MAX_CNT) & ret0);
  assign elig1 = (out1_reg < MAX_CNT) | ((out1_reg == MAX_CNT) & ret1);

  // Only an eligible requester can contest arbitration. An ineligible one
  // therefore never blocks the other requester.
  assign cand0 = req0_valid & elig0;
  assign cand1 = req1_valid & elig1;

  assign req0_ready = elig0 & (~cand1 |  last_gnt_reg);
  assign req1_ready = elig1 & (~cand0 | ~last_gnt_reg);

  assign gnt0 = req0_valid & req0_ready;
  assign gnt1 = req1_valid & req1_ready;

  assign dec0 = ret0 & (out0_reg != '0);
  assign dec1 = ret1 & (out1_reg != '0);

  always_comb begin
    out0_next = out0_reg;
    out1_next = out1_reg;
    if (gnt0 && !dec0) begin
      out0_next = out0_reg + CNT_ONE;
    end else if (!gnt0 && dec0) begin
      out0_next = out0_reg - CNT_ONE;
    end
    if (gnt1 && !dec1) begin
      out1_next = out1_reg + CNT_ONE;
    end else if (!gnt1 && dec1) begin
      out1_next = out1_reg - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out0_reg     <= '0;
      out1_reg     <= '0;
      last_gnt_reg <= 1'b1;
    end else begin
      out0_reg <= out0_next;
      out1_reg <= out1_next;
      if (gnt0) begin
        last_gnt_reg <= 1'b0;
      end else if (gnt1) begin
        last_gnt_reg <= 1'b1;
      end
    end
  end

  // Issue register. The operand outputs hold their last value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fas_enable      <= 1'b0;
      fas_a           <= '0;
      fas_b           <= '0;
      fas_sub         <= 1'b0;
      issue_owner_reg <= 1'b0;
      issue_tag_reg   <= '0;
    end else begin
      fas_enable <= gnt0 | gnt1;
      if (gnt0) begin
        fas_a           <= req0_a;
        fas_b           <= req0_b;
        fas_sub         <= req0_sub;
        issue_owner_reg <= 1'b0;
        issue_tag_reg   <= req0_tag;
      end else if (gnt1) begin
        fas_a           <= req1_a;
        fas_b           <= req1_b;
        fas_sub         <= req1_sub;
        issue_owner_reg <= 1'b1;
        issue_tag_reg   <= req1_tag;
      end
    end
  end

  // Shift sources. Slot 0 is fed from the issue register. Every later slot
  // is fed from its predecessor.
  for (genvar gi = 0; gi < LAT; gi++) begin : g_slot
    if (gi == 0) begin : g_head
      assign slot_vld_next[0]           = fas_enable;
      assign slot_owner_next[0]         = issue_owner_reg;
      assign slot_tag_next[0 +: TAG_W]  = issue_tag_reg;
    end else begin : g_shift
      assign slot_vld_next[gi]                 = slot_vld_reg[gi-1];
      assign slot_owner_next[gi]               = slot_owner_reg[gi-1];
      assign slot_tag_next[gi*TAG_W +: TAG_W]  = slot_tag_reg[(gi-1)*TAG_W +: TAG_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_reg   <= '0;
      slot_owner_reg <= '0;
      slot_tag_reg   <= '0;
    end else begin
      slot_vld_reg   <= slot_vld_next;
      slot_owner_reg <= slot_owner_next;
      slot_tag_reg   <= slot_tag_next;
    end
  end

  // Result routing. The data and tag registers of a requester are updated
  // only when that requester receives a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_tag   <= '0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_tag   <= '0;
      seq_err    <= 1'b0;
    end else begin
      rsp0_valid <= fas_valid & ret0;
      rsp1_valid <= fas_valid & ret1;
      if (fas_valid && ret0) begin
        rsp0_data <= fas_result;
        rsp0_tag  <= last_tag;
      end
      if (fas_valid && ret1) begin
        rsp1_data <= fas_result;
        rsp1_tag  <= last_tag;
      end
      // Set on a result without a tracked op, or a tracked op without a result.
      if (fas_valid != last_vld) begin
        seq_err <= 1'b1;
      end
    end
  end

  assign busy = (|slot_vld_reg) | fas_enable | rsp0_valid | rsp1_valid;

`ifdef FAS_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue0   <= '0;
      perf_issue1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (gnt0 && perf_issue0 != 16'hFFFF) begin
        perf_issue0 <= perf_issue0 + 16'd1;
      end
      if (gnt1 && perf_issue1 != 16'hFFFF) begin
        perf_issue1 <= perf_issue1 + 16'd1;
      end
      if (req0_valid && req1_valid && perf_conflict != 16'hFFFF) begin
        perf_conflict <= perf_conflict + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fas_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fas_issue_ctrl
//
// Self-checking bench for fas_issue_ctrl.
//
// Reference model:
//   - It keeps a list of issued ops, each recorded with its handshake cycle.
//   - Every expected output is derived from that list by cycle arithmetic:
//       enable     at handshake + 1
//       return     at handshake + LAT + 1
//       response   at handshake + LAT + 2
//   - Eligibility and round-robin follow the arbitration rules directly.
//
// Pipeline stand-in:
//   A small LAT-delayed pipeline model answers every observed fas_enable.
// -----------------------------------------------------------------------------
module tb_fas_issue_ctrl;

  localparam int LAT     = 4;
  localparam int MAX_OUT = 4;
  localparam int TAG_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             req0_sub = 1'b0, req1_sub = 1'b0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic             fas_enable;
  logic [31:0]      fas_a, fas_b;
  logic             fas_sub;
  logic             fas_valid = 1'b0;
  logic [31:0]      fas_result = '0;
  logic             rsp0_valid, rsp1_valid;
  logic [31:0]      rsp0_data, rsp1_data;
  logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
  logic             busy, seq_err;
`ifdef FAS_CTRL_PERF_EN
  logic [15:0]      perf_issue0, perf_issue1, perf_conflict;
`endif

  always #5 clk = ~clk;

  fas_issue_ctrl #(.LAT(LAT), .MAX_OUT(MAX_OUT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_sub(req0_sub), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_sub(req1_sub), .req1_tag(req1_tag),
    .fas_enable(fas_enable), .fas_a(fas_a), .fas_b(fas_b), .fas_sub(fas_sub),
    .fas_valid(fas_valid), .fas_result(fas_result),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_tag(rsp1_tag),
    .busy(busy), .seq_err(seq_err)
`ifdef FAS_CTRL_PERF_EN
    , .perf_issue0(perf_issue0), .perf_issue1(perf_issue1),
    .perf_conflict(perf_conflict)
`endif
  );

  typedef struct {
    int               hs;
    bit               own;
    logic [31:0]      a;
    logic [31:0]      b;
    bit               sub;
    logic [TAG_W-1:0] tag;
    bit               drop;
  } op_t;

  typedef struct {
    bit               v;
    logic [31:0]      a;
    logic [31:0]      b;
    bit               sub;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct {
    bit v0;
    bit v1;
    bit r0;
    bit r1;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  op_t         ops[$];
  bit          last1 = 1'b1;
  int          err_cyc = -1;
  bit          pv[32];
  logic [31:0] pr[32];

  // Pipeline stand-in: 1.0 + 2.0 yields 3.0. Any other input gives an
  // arbitrary but deterministic value.
  function automatic logic [31:0] fas_model(logic [31:0] a, logic [31:0] b, bit sub);
    if (a == 32'h3F800000 && b == 32'h40000000 && !sub) return 32'h40400000;
    return {a[31:16] ^ b[15:0], a[15:0] + b[31:16]} ^ {31'd0, sub};
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic bit model_elig(bit n);
    int cnt = 0;
    bit ret = 1'b0;
    foreach (ops[i]) begin
      if (ops[i].own == n) begin
        if (ops[i].hs < cyc && ops[i].hs + LAT + 1 >= cyc) cnt++;
        if (ops[i].hs + LAT + 1 == cyc) ret = 1'b1;
      end
    end
    return (cnt < MAX_OUT) || (cnt == MAX_OUT && ret);
  endfunction

  // Compares the registered outputs seen in the current cycle with the model.
  task automatic check_regs();
    bit               en_e = 1'b0;
    bit               busy_e = 1'b0;
    bit               r0e = 1'b0, r1e = 1'b0;
    op_t              eop;
    logic [31:0]      d0 = '0, d1 = '0;
    logic [TAG_W-1:0] t0 = '0, t1 = '0;
    foreach (ops[i]) begin
      if (ops[i].hs == cyc - 1) begin
        en_e = 1'b1;
        eop  = ops[i];
      end
      if (ops[i].hs == cyc - LAT - 2 && !ops[i].drop) begin
        if (ops[i].own) begin
          r1e = 1'b1; d1 = fas_model(ops[i].a, ops[i].b, ops[i].sub); t1 = ops[i].tag;
        end else begin
          r0e = 1'b1; d0 = fas_model(ops[i].a, ops[i].b, ops[i].sub); t0 = ops[i].tag;
        end
      end
      if (cyc >= ops[i].hs + 1 && cyc <= ops[i].hs + LAT + 2 - (ops[i].drop ? 1 : 0))
        busy_e = 1'b1;
    end
    chk("fas_enable", 32'(fas_enable), 32'(en_e));
    if (en_e) begin
      chk("fas_a", fas_a, eop.a);
      chk("fas_b", fas_b, eop.b);
      chk("fas_sub", 32'(fas_sub), 32'(eop.sub));
    end
    chk("rsp0_valid", 32'(rsp0_valid), 32'(r0e));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(r1e));
    if (r0e) begin
      chk("rsp0_data", rsp0_data, d0);
      chk("rsp0_tag", 32'(rsp0_tag), 32'(t0));
      $display("cyc %0d rsp0 data=%h tag=%0d", cyc, rsp0_data, rsp0_tag);
    end
    if (r1e) begin
      chk("rsp1_data", rsp1_data, d1);
      chk("rsp1_tag", 32'(rsp1_tag), 32'(t1));
      $display("cyc %0d rsp1 data=%h tag=%0d", cyc, rsp1_data, rsp1_tag);
    end
    chk("busy", 32'(busy), 32'(busy_e));
    chk("seq_err", 32'(seq_err), 32'(err_cyc >= 0 && cyc > err_cyc));
    while (ops.size() > 0 && ops[0].hs + LAT + 2 < cyc) ops.delete(0);
  endtask

  // One clock cycle: check registered outputs, run the pipeline stand-in,
  // drive the requests, then check ready and record the model's grant.
  task automatic cycle(input req_t q0, input req_t q1, input bit drop, input bit inj,
                       output bit r0, output bit r1);
    bit e0, e1, er0, er1;
    op_t nop;
    @(negedge clk);
    cyc++;
    check_regs();
    if (fas_enable) begin
      pv[(cyc + LAT) % 32] = 1'b1;
      pr[(cyc + LAT) % 32] = fas_model(fas_a, fas_b, fas_sub);
    end
    req0_valid = q0.v; req0_a = q0.a; req0_b = q0.b; req0_sub = q0.sub; req0_tag = q0.tag;
    req1_valid = q1.v; req1_a = q1.a; req1_b = q1.b; req1_sub = q1.sub; req1_tag = q1.tag;
    fas_valid  = pv[cyc % 32] && !drop;
    fas_result = pr[cyc % 32];
    pv[cyc % 32] = 1'b0;
    if (inj) begin
      fas_valid  = 1'b1;
      fas_result = 32'hBAD00001;
      if (err_cyc < 0) err_cyc = cyc;
    end
    if (drop) begin
      foreach (ops[i]) begin
        if (ops[i].hs + LAT + 1 == cyc) begin
          ops[i].drop = 1'b1;
          if (err_cyc < 0) err_cyc = cyc;
        end
      end
    end
    #1;
    e0  = model_elig(1'b0);
    e1  = model_elig(1'b1);
    er0 = e0 && (!(q1.v && e1) || last1);
    er1 = e1 && (!(q0.v && e0) || !last1);
    chk("req0_ready", 32'(req0_ready), 32'(er0));
    chk("req1_ready", 32'(req1_ready), 32'(er1));
    r0 = req0_ready;
    r1 = req1_ready;
    if (q0.v && er0) begin
      nop = '{hs: cyc, own: 1'b0, a: q0.a, b: q0.b, sub: q0.sub, tag: q0.tag, drop: 1'b0};
      ops.push_back(nop);
      last1 = 1'b0;
      $display("cyc %0d issue req0 a=%h b=%h sub=%0d tag=%0d", cyc, q0.a, q0.b, q0.sub, q0.tag);
    end else if (q1.v && er1) begin
      nop = '{hs: cyc, own: 1'b1, a: q1.a, b: q1.b, sub: q1.sub, tag: q1.tag, drop: 1'b0};
      ops.push_back(nop);
      last1 = 1'b1;
      $display("cyc %0d issue req1 a=%h b=%h sub=%0d tag=%0d", cyc, q1.a, q1.b, q1.sub, q1.tag);
    end
  endtask

  function automatic req_t rnd_req(bit v);
    req_t q;
    q.v   = v;
    q.a   = $urandom;
    q.b   = $urandom;
    q.sub = 1'($urandom_range(0, 1));
    q.tag = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
    return q;
  endfunction

  task automatic idle(input int n);
    bit r0, r1;
    req_t z;
    z = '{v: 1'b0, a: '0, b: '0, sub: 1'b0, tag: '0};
    for (int i = 0; i < n; i++) cycle(z, z, 1'b0, 1'b0, r0, r1);
  endtask

  task automatic do_reset(input bit chk_now);
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    fas_valid  = 1'b0;
    @(negedge clk);
    cyc++;
    if (chk_now) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fas_enable", 32'(fas_enable), 32'd0);
      chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("rst_seq_err", 32'(seq_err), 32'd0);
      chk("rst_req0_ready", 32'(req0_ready), 32'd1);
      chk("rst_req1_ready", 32'(req1_ready), 32'd1);
    end
    rst = 1'b0;
    ops.delete();
    for (int i = 0; i < 32; i++) pv[i] = 1'b0;
    last1   = 1'b1;
    err_cyc = -1;
  endtask

  initial begin
    vec_t tbl[9];
    bit   sat[10];
    bit   r0, r1;
    int   hs;
    req_t q0, q1, z;

    // Arbitration table, applied from reset with all counters at zero.
    tbl[0] = '{1, 1, 1, 0};
    tbl[1] = '{1, 1, 0, 1};
    tbl[2] = '{1, 0, 1, 0};
    tbl[3] = '{0, 1, 0, 1};
    tbl[4] = '{0, 0, 1, 1};
    tbl[5] = '{1, 1, 1, 0};
    tbl[6] = '{1, 1, 0, 1};
    tbl[7] = '{0, 1, 1, 1};
    tbl[8] = '{0, 1, 1, 1};
    // req0 held valid with no competition and MAX_OUT=4, LAT=4.
    sat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    z = '{v: 1'b0, a: '0, b: '0, sub: 1'b0, tag: '0};

    do_reset(1'b1);

    for (int i = 0; i < 9; i++) begin
      q0 = rnd_req(tbl[i].v0);
      q1 = rnd_req(tbl[i].v1);
      cycle(q0, q1, 1'b0, 1'b0, r0, r1);
      chk("tbl_ready0", 32'(r0), 32'(tbl[i].r0));
      chk("tbl_ready1", 32'(r1), 32'(tbl[i].r1));
    end
    idle(LAT + 4);

    // Single op: 1.0 + 2.0 with tag 3.
    q0 = '{v: 1'b1, a: 32'h3F800000, b: 32'h40000000, sub: 1'b0, tag: 4'd3};
    cycle(q0, z, 1'b0, 1'b0, r0, r1);
    hs = cyc;
    for (int k = 1; k <= LAT + 2; k++) begin
      idle(1);
      if (k == 1) chk("single_fas_enable", 32'(fas_enable), 32'd1);
      if (k == LAT + 2) begin
        chk("single_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("single_rsp0_data", rsp0_data, 32'h40400000);
        chk("single_rsp0_tag", 32'(rsp0_tag), 32'd3);
        chk("single_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("single_latency", 32'(cyc - hs), 32'(LAT + 2));
      end
    end
    idle(LAT + 2);

    // Outstanding limit: ready drops at the limit and comes back on a return.
    for (int k = 0; k < 10; k++) begin
      cycle(rnd_req(1'b1), z, 1'b0, 1'b0, r0, r1);
      chk("sat_ready0", 32'(r0), 32'(sat[k]));
    end
    idle(LAT + 4);

    // Random traffic: first mostly req0, then balanced.
    for (int k = 0; k < 300; k++) begin
      q0 = rnd_req($urandom_range(0, 99) < (k < 150 ? 90 : 60));
      q1 = rnd_req($urandom_range(0, 99) < (k < 150 ? 20 : 60));
      cycle(q0, q1, 1'b0, 1'b0, r0, r1);
    end
    idle(LAT + 4);

    // fas_valid while nothing is in flight.
    cycle(z, z, 1'b0, 1'b1, r0, r1);
    idle(1);
    chk("inj_seq_err", 32'(seq_err), 32'd1);
    chk("inj_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("inj_rsp1_valid", 32'(rsp1_valid), 32'd0);
    idle(5);
    chk("inj_seq_err_sticky", 32'(seq_err), 32'd1);

    // Lost result: the tracked op gets no fas_valid.
    do_reset(1'b0);
    cycle(z, rnd_req(1'b1), 1'b0, 1'b0, r0, r1);
    for (int k = 1; k <= LAT + 2; k++) cycle(z, z, (k == LAT + 1), 1'b0, r0, r1);
    chk("drop_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("drop_seq_err", 32'(seq_err), 32'd1);
    idle(2);
    // The counter must have been freed, so four back-to-back issues fit.
    for (int k = 0; k < 5; k++) cycle(z, rnd_req(1'b1), 1'b0, 1'b0, r0, r1);
    chk("drop_credit_ready1", 32'(r1), 32'd0);
    idle(LAT + 4);

    // Reset with three ops in flight, then an immediate conflict.
    do_reset(1'b0);
    cycle(rnd_req(1'b1), z, 1'b0, 1'b0, r0, r1);
    cycle(z, rnd_req(1'b1), 1'b0, 1'b0, r0, r1);
    cycle(rnd_req(1'b1), z, 1'b0, 1'b0, r0, r1);
    do_reset(1'b1);
    for (int k = 0; k < 10; k++) begin
      cycle(rnd_req(1'b1), rnd_req(1'b1), 1'b0, 1'b0, r0, r1);
      if (k == 0) begin
        chk("post_rst_ready0", 32'(r0), 32'd1);
        chk("post_rst_ready1", 32'(r1), 32'd0);
      end
    end
    idle(1);
`ifdef FAS_CTRL_PERF_EN
    chk("perf_conflict", 32'(perf_conflict), 32'd10);
    chk("perf_issue0", 32'(perf_issue0), 32'd5);
    chk("perf_issue1", 32'(perf_issue1), 32'd5);
`endif
    idle(LAT + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
